// File: rtl/pipe_decode_ctrl_pkg.sv
// rtl/pipe_decode_ctrl_pkg.sv - shared encodings, decode record and hazard helper
package pipe_decode_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LD = 3'd0,
    OP_CB = 3'd1,
    OP_R  = 3'd2,
    OP_ST = 3'd3,
    OP_I  = 3'd4,
    OP_B  = 3'd5,
    OP_M  = 3'd6
  } op_t;

  localparam logic [3:0] ALU_NONE   = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_OP4    = 4'd4;
  localparam logic [3:0] ALU_OP6    = 4'd6;
  localparam logic [3:0] ALU_PASS_B = 4'd7;
  localparam logic [3:0] ALU_OP9    = 4'd9;
  localparam logic [3:0] ALU_OP10   = 4'd10;
  localparam logic [3:0] ALU_MUL    = 4'd13;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FULL   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  typedef struct packed {
    op_t        op;
    logic [3:0] alu_code;
    logic       uncond_branch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [4:0] read_reg1;
    logic [4:0] read_reg2;
    logic [4:0] write_reg;
  } decode_t;

  // True when the decoded instruction actually consumes register r as a source.
  function automatic logic reads_reg(decode_t d, logic [4:0] r);
    logic rs1;
    logic rs2;
    rs1 = (d.op != OP_B) && (d.op != OP_M) && (d.read_reg1 == r);
    rs2 = ((d.op == OP_R) || (d.op == OP_CB) || (d.op == OP_ST)) && (d.read_reg2 == r);
    return rs1 || rs2;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational instruction word to control record decoder
module instr_decode
  import pipe_decode_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output decode_t     dec
);

  op_t  op;
  logic unused_bits;

  assign unused_bits = ^{instruction[31], instruction[21], instruction[15:10]};

  always_comb begin
    if (instruction[26])       op = instruction[29] ? OP_CB : OP_B;
    else if (!instruction[28]) op = OP_R;
    else if (instruction[23])  op = OP_M;
    else if (instruction[22])  op = OP_LD;
    else if (instruction[27])  op = OP_ST;
    else                       op = OP_I;
  end

  always_comb begin
    dec               = '0;
    dec.op            = op;
    dec.branch        = (op == OP_CB);
    dec.uncond_branch = (op == OP_B);
    dec.mem_read      = (op == OP_LD);
    dec.mem_to_reg    = (op == OP_LD);
    dec.mem_write     = (op == OP_ST);
    dec.alu_src       = !((op == OP_R) || (op == OP_CB));
    dec.reg_write     = (op == OP_R) || (op == OP_LD) || (op == OP_M);
    dec.read_reg1     = instruction[9:5];
    dec.read_reg2     = ((op == OP_CB) || (op == OP_ST)) ? instruction[4:0] : instruction[20:16];
    dec.write_reg     = instruction[4:0];

    case (op)
      OP_LD, OP_ST: dec.alu_code = ALU_ADD;
      OP_CB:        dec.alu_code = ALU_PASS_B;
      OP_M:         dec.alu_code = ALU_MUL;
      OP_R: begin
        if (instruction[24])       dec.alu_code = instruction[30] ? ALU_OP10 : ALU_ADD;
        else if (!instruction[29]) dec.alu_code = ALU_OP6;
        else if (!instruction[30]) dec.alu_code = ALU_OP4;
        else                       dec.alu_code = ALU_OP9;
      end
      OP_I: begin
        if (instruction[29])      dec.alu_code = ALU_OP4;
        else if (instruction[30]) dec.alu_code = instruction[25] ? ALU_OP9 : ALU_OP10;
        else if (instruction[25]) dec.alu_code = ALU_OP6;
        else                      dec.alu_code = ALU_ADD;
      end
      default: dec.alu_code = ALU_NONE;
    endcase
  end

endmodule

// File: rtl/pipe_decode_ctrl.sv
// rtl/pipe_decode_ctrl.sv - registered decode stage with load-use interlock and bubble counter
module pipe_decode_ctrl
  import pipe_decode_ctrl_pkg::*;
#(
  parameter bit HAZARD_EN   = 1'b1,
  parameter int STALL_CNT_W = 16,
  parameter int ZR_INDEX    = 31
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            instruction,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             op_type,
  output logic [3:0]             alu_code,
  output logic                   uncond_branch,
  output logic                   branch,
  output logic                   mem_read,
  output logic                   mem_to_reg,
  output logic                   mem_write,
  output logic                   alu_src,
  output logic                   reg_write,
  output logic [4:0]             read_reg1,
  output logic [4:0]             read_reg2,
  output logic [4:0]             write_reg,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [4:0] ZR_REG = 5'(ZR_INDEX);

  state_t                 state_q;
  state_t                 state_d;
  decode_t                dec_in;
  decode_t                dec_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   hazard;
  logic                   capture;
  logic                   bump;

  instr_decode u_decode (
    .instruction (instruction),
    .dec         (dec_in)
  );

  // A held load must not issue alongside a consumer of its destination.
  always_comb begin
    hazard = HAZARD_EN && (state_q == ST_FULL) && in_valid &&
             (dec_q.op == OP_LD) && (dec_q.write_reg != ZR_REG) &&
             reads_reg(dec_in, dec_q.write_reg);
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    bump      = 1'b0;
    in_ready  = 1'b0;
    out_valid = (state_q == ST_FULL);

    if (!reset && !flush) begin
      in_ready = (state_q == ST_FULL) ? (out_ready && !hazard) : 1'b1;
    end

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY, ST_BUBBLE: begin
          state_d = in_valid ? ST_FULL : ST_EMPTY;
          capture = in_valid;
        end
        ST_FULL: begin
          if (out_ready) begin
            if (hazard) begin
              state_d = ST_BUBBLE;
              bump    = 1'b1;
            end else if (in_valid) begin
              state_d = ST_FULL;
              capture = 1'b1;
            end else begin
              state_d = ST_EMPTY;
            end
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      dec_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        dec_q <= dec_in;
      end
      if (bump && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_CNT_W'(1);
      end
    end
  end

  assign op_type       = dec_q.op;
  assign alu_code      = dec_q.alu_code;
  assign uncond_branch = dec_q.uncond_branch;
  assign branch        = dec_q.branch;
  assign mem_read      = dec_q.mem_read;
  assign mem_to_reg    = dec_q.mem_to_reg;
  assign mem_write     = dec_q.mem_write;
  assign alu_src       = dec_q.alu_src;
  assign reg_write     = dec_q.reg_write;
  assign read_reg1     = dec_q.read_reg1;
  assign read_reg2     = dec_q.read_reg2;
  assign write_reg     = dec_q.write_reg;
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// tb/tb_pipe_decode_ctrl.sv - directed and randomized checks of pipe_decode_ctrl
module tb_pipe_decode_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, uncond_branch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [2:0]  op_type;
  logic [3:0]  alu_code;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [15:0] stall_count;

  logic        n_in_ready, n_out_valid, n_uncond_branch, n_branch, n_mem_read, n_mem_to_reg, n_mem_write, n_alu_src, n_reg_write;
  logic [2:0]  n_op_type;
  logic [3:0]  n_alu_code;
  logic [4:0]  n_read_reg1, n_read_reg2, n_write_reg;
  logic [15:0] n_stall_count;

  logic [28:0] f1, f2;
  assign f1 = {op_type, alu_code, uncond_branch, branch, mem_read, mem_to_reg, mem_write,
               alu_src, reg_write, read_reg1, read_reg2, write_reg};
  assign f2 = {n_op_type, n_alu_code, n_uncond_branch, n_branch, n_mem_read, n_mem_to_reg, n_mem_write,
               n_alu_src, n_reg_write, n_read_reg1, n_read_reg2, n_write_reg};

  int errs   = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pipe_decode_ctrl #(.HAZARD_EN(1'b1), .STALL_CNT_W(16), .ZR_INDEX(31)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .op_type(op_type), .alu_code(alu_code),
    .uncond_branch(uncond_branch), .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .read_reg1(read_reg1),
    .read_reg2(read_reg2), .write_reg(write_reg), .stall_count(stall_count)
  );

  pipe_decode_ctrl #(.HAZARD_EN(1'b0), .STALL_CNT_W(16), .ZR_INDEX(31)) dut_nohaz (
    .clock(clock), .reset(reset), .instruction(instruction), .in_valid(in_valid), .in_ready(n_in_ready),
    .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready), .op_type(n_op_type), .alu_code(n_alu_code),
    .uncond_branch(n_uncond_branch), .branch(n_branch), .mem_read(n_mem_read), .mem_to_reg(n_mem_to_reg),
    .mem_write(n_mem_write), .alu_src(n_alu_src), .reg_write(n_reg_write), .read_reg1(n_read_reg1),
    .read_reg2(n_read_reg2), .write_reg(n_write_reg), .stall_count(n_stall_count)
  );

  function automatic int ref_op(logic [31:0] w);
    if (w[26])       return w[29] ? 1 : 5;
    else if (!w[28]) return 2;
    else if (w[23])  return 6;
    else if (w[22])  return 0;
    else if (w[27])  return 3;
    else             return 4;
  endfunction

  function automatic logic [4:0] ref_rr2(logic [31:0] w);
    int op;
    op = ref_op(w);
    return (op == 1 || op == 3) ? w[4:0] : w[20:16];
  endfunction

  function automatic logic [28:0] ref_fields(logic [31:0] w);
    int op;
    int alu;
    op = ref_op(w);
    case (op)
      0, 3: alu = 2;
      1:    alu = 7;
      6:    alu = 13;
      2:    alu = w[24] ? (w[30] ? 10 : 2) : (!w[29] ? 6 : (!w[30] ? 4 : 9));
      4:    alu = w[29] ? 4 : (w[30] ? (w[25] ? 9 : 10) : (w[25] ? 6 : 2));
      default: alu = 0;
    endcase
    return {3'(op), 4'(alu), op == 5, op == 1, op == 0, op == 0, op == 3,
            !(op == 2 || op == 1), (op == 2 || op == 0 || op == 6),
            w[9:5], ref_rr2(w), w[4:0]};
  endfunction

  function automatic bit ref_reads(logic [31:0] w, logic [4:0] r);
    int op;
    op = ref_op(w);
    return (!(op == 5 || op == 6) && w[9:5] == r) ||
           ((op == 2 || op == 1 || op == 3) && ref_rr2(w) == r);
  endfunction

  function automatic bit load_use(logic [31:0] ld, logic [31:0] nxt);
    return (ref_op(ld) == 0) && (ld[4:0] != 5'd31) && ref_reads(nxt, ld[4:0]);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [4:0]  pool [4];
    pool = '{5'd1, 5'd2, 5'd3, 5'd31};
    w = $urandom;
    w[4:0]   = pool[$urandom_range(0, 3)];
    w[9:5]   = pool[$urandom_range(0, 3)];
    w[20:16] = pool[$urandom_range(0, 3)];
    if ($urandom_range(0, 2) == 0) begin
      w[28] = 1'b1; w[26] = 1'b0; w[23] = 1'b0; w[22] = 1'b1;
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] I_ADD   = 32'h8B030041;
  localparam logic [31:0] I_LD5   = 32'hF84000C5;
  localparam logic [31:0] I_ADD5  = 32'h8B0800A7;
  localparam logic [31:0] I_LDZR  = 32'hF84000DF;
  localparam logic [31:0] I_ADDZR = 32'h8B0803E7;
  localparam logic [31:0] I_ADDI  = 32'h91000421;

  logic [31:0] q[$];
  logic [31:0] last_iss;
  int          last_iss_cyc;
  bit          have_last;
  int          exp_stall;
  bit          exp_ov, exp_ir, haz, iss;

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1; instruction = I_ADD;
    #1;
    chk("rst_in_ready", in_ready, 0);
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", f1, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_in_ready_held", in_ready, 0);

    reset = 1'b0;
    #1;
    chk("add_in_ready", in_ready, 1);
    step();
    chk("add_out_valid", out_valid, 1);
    chk("add_fields", f1, ref_fields(I_ADD));
    chk("add_op_type", op_type, 2);
    chk("add_alu_code", alu_code, 2);
    chk("add_rw_asrc", {reg_write, alu_src}, 2'b10);
    in_valid = 1'b0;
    step();
    chk("add_drain", out_valid, 0);

    in_valid = 1'b1; instruction = I_LD5;
    step();
    chk("lu_ld_valid", out_valid, 1);
    chk("lu_ld_fields", f1, ref_fields(I_LD5));
    instruction = I_ADD5;
    #1;
    chk("lu_haz_in_ready", in_ready, 0);
    step();
    chk("lu_bubble", out_valid, 0);
    chk("lu_stall", stall_count, 1);
    chk("lu_bubble_in_ready", in_ready, 1);
    chk("nohaz_b2b_valid", n_out_valid, 1);
    chk("nohaz_b2b_fields", f2, ref_fields(I_ADD5));
    chk("nohaz_stall", n_stall_count, 0);
    step();
    chk("lu_add_valid", out_valid, 1);
    chk("lu_add_fields", f1, ref_fields(I_ADD5));
    in_valid = 1'b0;
    step();
    chk("lu_drain", out_valid, 0);

    in_valid = 1'b1; instruction = I_LDZR;
    step();
    chk("zr_ld_valid", out_valid, 1);
    instruction = I_ADDZR;
    #1;
    chk("zr_in_ready", in_ready, 1);
    step();
    chk("zr_add_valid", out_valid, 1);
    chk("zr_add_fields", f1, ref_fields(I_ADDZR));
    chk("zr_stall", stall_count, 1);
    in_valid = 1'b0;
    step();

    in_valid = 1'b1; instruction = I_ADD;
    step();
    out_ready = 1'b0; instruction = I_ADDI;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_hold", f1, ref_fields(I_ADD));
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_fields", f1, ref_fields(I_ADDI));
    in_valid = 1'b0;
    step();

    in_valid = 1'b1; instruction = I_ADD;
    step();
    flush = 1'b1; instruction = I_ADDI;
    #1;
    chk("fl_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    #1;
    chk("fl_empty_ready", in_ready, 1);
    step();
    chk("fl_not_captured", out_valid, 0);

    exp_stall = 1;
    have_last = 1'b0;
    last_iss_cyc = -10;
    last_iss = '0;
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 29) == 0);
      instruction = gen_instr();
      #1;
      exp_ov = (q.size() > 0);
      chk("rnd_out_valid", out_valid, exp_ov);
      if (exp_ov) chk("rnd_fields", f1, ref_fields(q[0]));
      haz    = exp_ov && in_valid && load_use(q[0], instruction);
      exp_ir = flush ? 1'b0 : (!exp_ov ? 1'b1 : (out_ready && !haz));
      chk("rnd_in_ready", in_ready, exp_ir);
      iss = out_valid && out_ready && !flush && exp_ov;
      if (iss) begin
        if (have_last && load_use(last_iss, q[0]))
          chk("rnd_spacing", (c - last_iss_cyc) >= 2, 1);
        have_last    = 1'b1;
        last_iss     = q[0];
        last_iss_cyc = c;
      end
      if (exp_ov && out_ready && haz && !flush) exp_stall++;
      if (flush) q.delete();
      else begin
        if (exp_ov && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) q.push_back(instruction);
      end
      step();
      chk("rnd_stall", stall_count, 16'(exp_stall));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipe_decode_ctrl.md
PIPE_DECODE_CTRL -- requirements
Module: pipe_decode_ctrl

Interface
REQ-001 SHALL have parameter HAZARD_EN, default 1, meaning 1 enables the load-use interlock and 0 disables it.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning the width of the bubble counter.
REQ-003 SHALL have parameter ZR_INDEX, default 31, meaning the zero-register index, which is never a hazard source.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 instruction  in  32  instruction word from the instruction cache.
REQ-007 in_valid / in_ready  in / out  1 each  intake handshake.
REQ-008 flush  in  1  discards the held decode (taken-branch redirect).
REQ-009 out_valid / out_ready  out / in  1 each  issue handshake.
REQ-010 op_type  out  3  LD=0, CB=1, R=2, ST=3, I=4, B=5, M=6.
REQ-011 alu_code  out  4  ALU operation code.
REQ-012 uncond_branch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  control flags.
REQ-013 read_reg1, read_reg2, write_reg  out  5 each  register indices.
REQ-014 stall_count  out  STALL_CNT_W  number of bubbles inserted since reset.

Function
REQ-015 op_type: bit26=1 gives CB if bit29=1, else B; else bit28=0 gives R; else bit23=1 gives M; else bit22=1 gives LD; else bit27=1 gives ST; else I.
REQ-016 Flags: branch = CB; uncond_branch = B; mem_read and mem_to_reg = LD; mem_write = ST; alu_src = 0 for R and CB, else 1; reg_write = R, LD or M.
REQ-017 Registers: read_reg1 = [9:5]; read_reg2 = [4:0] for CB and ST, else [20:16]; write_reg = [4:0].
REQ-018 alu_code: LD/ST→2; CB→7; M→13.
REQ-019 alu_code for R: bit24=1 gives 2 (bit30=0) or 10 (bit30=1); else bit29=0 gives 6; else bit30=0 gives 4; else 9.
REQ-020 alu_code for I: bit29=1 gives 4; else bit30=1 gives 9 (bit25=1) or 10 (bit25=0); else bit25=1 gives 6; else 2. For B: 0.
REQ-021 All decode outputs are registered; latency from intake handshake to out_valid is 1 cycle; outputs are held stable while out_valid=1 and out_ready=0.
REQ-022 FSM states: EMPTY, FULL, BUBBLE.
REQ-023 in_ready=1 in EMPTY and BUBBLE; in FULL, in_ready = out_ready AND NOT hazard; in_ready=0 whenever flush=1.
REQ-024 out_valid=1 only in FULL.
REQ-025 hazard = HAZARD_EN AND held op is LD AND held write_reg≠ZR_INDEX AND the incoming instruction reads that register.
REQ-026 For hazard, read_reg1 counts as read for all types except B and M; read_reg2 counts as read for R, CB and ST only.
REQ-027 EMPTY/BUBBLE: in_valid → FULL (capture); otherwise → EMPTY.
REQ-028 FULL: out_ready=0 → stay FULL.
REQ-029 FULL with out_ready=1: hazard → BUBBLE (stall_count+1); else in_valid → FULL with the new capture; else → EMPTY.
REQ-030 Load-use spacing is exactly one empty issue cycle between the LD and its consumer.
REQ-031 flush=1 → EMPTY next cycle regardless of state or handshakes; the held op is dropped and no capture occurs; flush outranks all but reset.
REQ-032 stall_count saturates at all-ones and never wraps.

Reset
REQ-033 On reset=1 at a clock edge: state EMPTY, all decode outputs 0, stall_count 0, out_valid 0; in_ready=0 during the reset cycle.

Structure
REQ-034 Shared package holds the op_type encodings, ALU code constants (2, 4, 6, 7, 9, 10, 13) and the FSM state enum.
REQ-035 One combinational sub-module, instr_decode, maps instruction to op_type, flags, alu_code and register indices; pipe_decode_ctrl holds the FSM, the registers, hazard compare and counter.

Verification
REQ-036 Reset, then ADD X1,X2,X3 (0x8B030041) with out_ready=1 → next cycle out_valid=1, op_type=2, alu_code=2, reg_write=1, alu_src=0.
REQ-037 LDUR X5,[X6] then ADD X7,X5,X8 back-to-back → exactly one out_valid=0 cycle between them; stall_count=1.
REQ-038 Same pair with LDUR destination X31 (ZR) → no bubble; stall_count stays 0.
REQ-039 FULL with out_ready=0 for 4 cycles → outputs stable, in_ready=0; on release, the next instruction issues the following cycle.
REQ-040 flush asserted in FULL with in_valid=1 → out_valid=0 next cycle, instruction not captured, state EMPTY.
REQ-041 HAZARD_EN=0 with the LDUR/ADD pair → no bubble, back-to-back issue.
